gbx_sram: RTL and testbench

GBX_SRAM -- requirements
Module: gbx_sram

---
 rtl/gbx_sram.sv | 170 +++++++++++++++++
 tb/tb_gbx_sram.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gbx_sram.sv
// rtl/gbx_sram.sv - word SRAM with burst request/response port and per-transaction sticky error flags
// Optional feature macro: GBX_SRAM_RANGECHK_EN (flag beats beyond the array instead of wrapping)
`timescale 1ns/1ps
module gbx_sram #(
    parameter int DEPTH = 16384,
    parameter int AW    = 14
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        greqvalid,
    input  logic        greqwrite,
    input  logic [31:0] greqaddr,
    input  logic [3:0]  greqlen,
    input  logic [15:0] greqid,
    input  logic        greqdvalid,
    input  logic [31:0] greqdata,
    input  logic [1:0]  greqsize,
    input  logic        greqdlast,
    input  logic [15:0] grequser,
    output logic        greqready,
    output logic        grspvalid,
    output logic [31:0] grspdata,
    output logic        grspwerr,
    output logic        grsprerr,
    output logic [15:0] grspid,
    output logic        grsplast,
    output logic [15:0] grspuser,
    input  logic        grspready
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] WRSP = 2'd3;

    reg [31:0] mem [0:DEPTH-1];

    logic [1:0]  state, state_n;
    logic        ready_q;
    logic [31:0] addr_q;
    logic [3:0]  len_q, cnt_q;
    logic [1:0]  size_q;
    logic [15:0] id_q, user_q;
    logic        err_q;

    logic        accept, beat_wr, beat_rd, wr_last, rd_last;
    logic [31:0] cur_addr, next_addr, rd_word, wdata;
    logic [1:0]  cur_size;
    logic [3:0]  cur_cnt, cur_len, wstrb;
    logic        misalign, range_err, beat_err;

    // In IDLE the first write beat can ride with the request, so beat attributes come from the inputs
    always_comb begin
        cur_addr  = (state == IDLE) ? greqaddr : addr_q;
        cur_size  = (state == IDLE) ? greqsize : size_q;
        cur_cnt   = (state == IDLE) ? 4'd0     : cnt_q;
        cur_len   = (state == IDLE) ? greqlen  : len_q;
        next_addr = cur_addr + (32'd1 << cur_size);
        accept    = (state == IDLE) && greqvalid && ready_q;
        beat_wr   = ready_q && greqdvalid &&
                    (((state == IDLE) && greqvalid && greqwrite) || (state == WR));
        beat_rd   = (state == RD) && grspready;
        wr_last   = greqdlast || (cur_cnt == cur_len);
        rd_last   = (cnt_q == len_q);
    end

    // Alignment check for the current beat; size 3 is never legal
    always_comb begin
        misalign = 1'b0;
        case (cur_size)
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = cur_addr[0];
            2'd2:    misalign = |cur_addr[1:0];
            default: misalign = 1'b1;
        endcase
    end

`ifdef GBX_SRAM_RANGECHK_EN
    assign range_err = (64'(cur_addr) >= 64'(DEPTH) * 64'd4);
`else
    assign range_err = 1'b0;
`endif
    assign beat_err = misalign || range_err;

    // Byte-lane strobes; data is replicated so every enabled lane sees the right bytes
    always_comb begin
        wstrb = 4'b0000;
        wdata = greqdata;
        case (cur_size)
            2'd0: begin
                wstrb = 4'b0001 << cur_addr[1:0];
                wdata = {4{greqdata[7:0]}};
            end
            2'd1: begin
                wstrb = cur_addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{greqdata[15:0]}};
            end
            2'd2:    wstrb = 4'b1111;
            default: wstrb = 4'b0000;
        endcase
    end

    // Storage update: masked byte writes on each accepted error-free write beat; never reset
    always_ff @(posedge clk) begin
        if (beat_wr && !beat_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[cur_addr[AW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rd_word = mem[addr_q[AW+1:2]];

    // Next-state selection for the transaction sequencer
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) begin
                if (!greqwrite)             state_n = RD;
                else if (beat_wr && wr_last) state_n = WRSP;
                else                        state_n = WR;
            end
            RD:      if (beat_rd && rd_last) state_n = IDLE;
            WR:      if (beat_wr && wr_last) state_n = WRSP;
            default: if (grspready)          state_n = IDLE;
        endcase
    end

    // Transaction registers: latch request, advance beat address/count, accumulate sticky error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            size_q  <= '0;
            id_q    <= '0;
            user_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            ready_q <= (state_n == IDLE) || (state_n == WR);
            if (accept) begin
                addr_q <= greqaddr;
                len_q  <= greqlen;
                size_q <= greqsize;
                id_q   <= greqid;
                user_q <= grequser;
                cnt_q  <= 4'd0;
            end
            if (beat_wr || beat_rd) begin
                addr_q <= next_addr;
                cnt_q  <= cur_cnt + 4'd1;
            end
            if (state_n == IDLE)
                err_q <= 1'b0;
            else if (beat_wr || beat_rd)
                err_q <= err_q || beat_err;
        end
    end

    assign greqready = ready_q;
    assign grspvalid = (state == RD) || (state == WRSP);
    assign grspdata  = ((state == RD) && !beat_err) ? rd_word : 32'd0;
    assign grsprerr  = (state == RD) && (err_q || beat_err);
    assign grspwerr  = (state == WRSP) && err_q;
    assign grsplast  = ((state == RD) && rd_last) || (state == WRSP);
    assign grspid    = id_q;
    assign grspuser  = user_q;
endmodule

// File: tb/tb_gbx_sram.sv
// tb/tb_gbx_sram.sv - scoreboard bench for gbx_sram with random bursts against a memory model
`timescale 1ns/1ps
module tb_gbx_sram;
    localparam int DEPTH = 16384;
    localparam int AW    = 14;

    logic        clk = 1'b0, reset = 1'b0;
    logic        greqvalid = 0, greqwrite = 0, greqdvalid = 0, greqdlast = 0;
    logic [31:0] greqaddr = 0, greqdata = 0;
    logic [3:0]  greqlen = 0;
    logic [1:0]  greqsize = 0;
    logic [15:0] greqid = 0, grequser = 0;
    logic        greqready, grspvalid, grspwerr, grsprerr, grsplast;
    logic [31:0] grspdata;
    logic [15:0] grspid, grspuser;
    logic        grspready = 1'b0;

    always #5 clk = ~clk;

    gbx_sram #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .greqvalid(greqvalid), .greqwrite(greqwrite), .greqaddr(greqaddr), .greqlen(greqlen),
        .greqid(greqid), .greqdvalid(greqdvalid), .greqdata(greqdata), .greqsize(greqsize),
        .greqdlast(greqdlast), .grequser(grequser), .greqready(greqready),
        .grspvalid(grspvalid), .grspdata(grspdata), .grspwerr(grspwerr), .grsprerr(grsprerr),
        .grspid(grspid), .grsplast(grsplast), .grspuser(grspuser), .grspready(grspready)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        werr;
        logic        rerr;
        logic        last;
        logic [15:0] id;
        logic [15:0] user;
    } rsp_t;

    rsp_t        exp_q[$];
    int          total = 0, bad = 0;
    logic [31:0] model [0:DEPTH-1];
    int          rdy_mode = 2;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic bit beat_bad(input logic [31:0] a, input logic [1:0] s);
        bit e;
        e = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
`ifdef GBX_SRAM_RANGECHK_EN
        if (a >= 32'(4 * DEPTH)) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic int unsigned widx(input logic [31:0] a);
        return int'((a >> 2) % 32'(DEPTH));
    endfunction

    task automatic apply(input logic [31:0] ba, input logic [1:0] sz, input logic [31:0] d, inout bit st);
        int unsigned w;
        w = widx(ba);
        if (beat_bad(ba, sz)) st = 1'b1;
        else if (sz == 2'd0) model[w][8*ba[1:0] +: 8] = d[7:0];
        else if (sz == 2'd1) model[w][16*ba[1] +: 16] = d[15:0];
        else model[w] = d;
    endtask

    // Response acceptance policy: random, alternating, or always ready
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0)      grspready = 1'($urandom_range(0, 1));
        else if (rdy_mode == 1) grspready = ~grspready;
        else                    grspready = 1'b1;
    end

    // Monitor: pop and compare on every accepted response; stalled beats must hold still
    rsp_t held;
    bit   have_held = 0;
    always @(negedge clk) begin
        rsp_t cur;
        cur = {grspdata, grspwerr, grsprerr, grsplast, grspid, grspuser};
        if (!reset) have_held = 0;
        else if (grspvalid) begin
            if (have_held) check("hold", 128'(cur), 128'(held));
            if (grspready) begin
                have_held = 0;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp actual=%h required=none", cur);
                end else begin
                    check("rsp", 128'(cur), 128'(exp_q.pop_front()));
                end
            end else begin
                held = cur;
                have_held = 1;
            end
        end else have_held = 0;
    end

    task automatic wait_req_ready();
        int n = 0;
        while (!greqready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!greqready) begin
            total++;
            bad++;
            $display("FAIL req_ready_timeout actual=0 required=1");
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] len, input logic [1:0] sz,
                           input logic [15:0] id, input logic [15:0] user, input bit chk_lat);
        bit          st = 0, e;
        logic [31:0] ba;
        for (int i = 0; i <= int'(len); i++) begin
            ba = a + 32'(i) * (32'd1 << sz);
            e  = beat_bad(ba, sz);
            st = st | e;
            exp_q.push_back({e ? 32'd0 : model[widx(ba)], 1'b0, st, (i == int'(len)), id, user});
        end
        greqvalid = 1; greqwrite = 0; greqaddr = a; greqlen = len; greqsize = sz;
        greqid = id; grequser = user; greqdvalid = 0; greqdlast = 0;
        wait_req_ready();
        @(posedge clk); #1;
        greqvalid = 0;
        if (chk_lat) check("first_beat_latency", 128'(grspvalid), 128'(1));
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0] len, input logic [1:0] sz,
                            input logic [15:0] id, input logic [15:0] user, input int nb,
                            input bit first, input bit cnt_end, input int abort_at,
                            input logic [31:0] d0);
        bit          st = 0, aborted = 0;
        int          beat = 0;
        logic [31:0] d;
        greqvalid = 1; greqwrite = 1; greqaddr = a; greqlen = len; greqsize = sz;
        greqid = id; grequser = user;
        greqdvalid = first; greqdata = d0;
        greqdlast = first && (nb == 1) && (nb < int'(len) + 1 || !cnt_end);
        wait_req_ready();
        @(posedge clk); #1;
        if (first) begin
            apply(a, sz, d0, st);
            beat = 1;
        end
        // keep a scrambled request asserted; it must be ignored while busy
        greqaddr = $urandom; greqid = ~id; grequser = 16'($urandom);
        greqsize = 2'($urandom); greqlen = 4'($urandom); greqwrite = 1'($urandom);
        greqdvalid = 0; greqdlast = 0;
        while (beat < nb) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            d = (beat == 0) ? d0 : $urandom;
            greqdata = d; greqdvalid = 1;
            greqdlast = (beat == nb - 1) && (nb < int'(len) + 1 || !cnt_end);
            if (beat == abort_at) begin
                #1 reset = 0;
                aborted = 1;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            apply(a + 32'(beat) * (32'd1 << sz), sz, d, st);
            beat++;
            greqdvalid = 0; greqdlast = 0;
        end
        greqvalid = 0; greqdvalid = 0; greqdlast = 0;
        if (!aborted) exp_q.push_back({32'd0, st, 1'b0, 1'b1, id, user});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            dut.mem[i] = v;
            model[i] = v;
        end
        dut.mem[14'h1800] = 32'hDEADBEEF;
        model[14'h1800]   = 32'hDEADBEEF;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 128'({greqready, grspvalid, grsplast, grspwerr, grsprerr,
                                     grspdata, grspid, grspuser}), 128'(0));
        reset = 1;
        check("ready_before_first_edge", 128'(greqready), 128'(0));
        @(posedge clk); #1;
        check("ready_after_first_edge", 128'(greqready), 128'(1));

        rdy_mode = 2;
        do_read(32'h6000, 4'd0, 2'd2, 16'h0012, 16'h0034, 1);
        drain();
        do_write(32'h6001, 4'd0, 2'd0, 16'h0055, 16'h0066, 1, 1, 0, -1, 32'h000000AA);
        drain();
        check("byte_write_word", 128'(dut.mem[14'h1800]), 128'(32'hDEADAAEF));

        rdy_mode = 1;
        do_read(32'h100, 4'd3, 2'd2, 16'h0101, 16'h0202, 1);
        drain();
        rdy_mode = 2;

        do_write(32'h102, 4'd0, 2'd2, 16'h0303, 16'h0404, 1, 1, 0, -1, 32'h12345678);
        drain();
        check("misaligned_write_untouched", 128'(dut.mem[14'h40]), 128'(model[14'h40]));

        do_read(32'h10000, 4'd0, 2'd2, 16'h0505, 16'h0606, 1);
        drain();

        do_write(32'h200, 4'd3, 2'd2, 16'h0707, 16'h0808, 4, 1, 0, 1, 32'hCAFEF00D);
        check("abort_outputs_zero", 128'({greqready, grspvalid, grsplast, grspwerr, grsprerr,
                                          grspdata, grspid, grspuser}), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        @(posedge clk); #1;
        check("abort_ready_after_release", 128'(greqready), 128'(1));
        do_read(32'h200, 4'd3, 2'd2, 16'h0909, 16'h0A0A, 0);
        drain();

        for (int t = 0; t < 60; t++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            logic [3:0]  len;
            int          nb;
            a   = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 'h1FFFF))
                                              : 32'($urandom_range(0, 'h3FF));
            sz  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            len = 4'($urandom_range(0, 7));
            rdy_mode = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) begin
                nb = $urandom_range(1, int'(len) + 1);
                do_write(a, len, sz, 16'($urandom), 16'($urandom), nb,
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, $urandom);
            end else begin
                do_read(a, len, sz, 16'($urandom), 16'($urandom), 0);
            end
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
